// File: rtl/emergency_arbiter.sv
// Debounced multi-source SOS latching with an IDLE/ALARM/CLEARING FSM and a maintenance hold-to-clear.
// Define SOS_ALARM_BLINK_EN for a blinking alarm_led; the default build drives alarm_led steady with sos_mode.
module emergency_arbiter #(
  parameter int unsigned N_SRC           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned BLINK_HALF      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_SRC-1:0]         sos_button,
  input  logic                     clear_request,
  output logic                     sos_mode,
  output logic [N_SRC-1:0]         active_src,
  output logic [$clog2(N_SRC)-1:0] first_src,
  output logic                     alarm_led
);

  localparam int unsigned SRC_W  = $clog2(N_SRC);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ALARM    = 2'd1;
  localparam logic [1:0] ST_CLEARING = 2'd2;

  // Elaboration-time parameter range guards
  if (N_SRC < 2 || N_SRC > 16) begin : g_bad_n_src
    $error("emergency_arbiter: N_SRC out of range");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("emergency_arbiter: DEBOUNCE_CYCLES out of range");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("emergency_arbiter: HOLD_CYCLES out of range");
  end
  if (BLINK_HALF < 1 || BLINK_HALF > 255) begin : g_bad_blink
    $error("emergency_arbiter: BLINK_HALF out of range");
  end

  logic [1:0]                  state_q, state_d;
  logic [N_SRC-1:0]            active_src_q, active_src_d;
  logic [N_SRC-1:0]            latch_now;
  logic [SRC_W-1:0]            first_src_q, first_src_d;
  logic [SRC_W-1:0]            lowest_src;
  logic [HOLD_W-1:0]           hold_q, hold_d;
  logic [N_SRC-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic                        sos_mode_q, sos_mode_d;
  logic                        alarm_led_q, alarm_led_d;
  logic                        clear_done;

`ifdef SOS_ALARM_BLINK_EN
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);
  logic [BLINK_W-1:0]          blink_cnt_q, blink_cnt_d;
`endif

  // Per-source saturating debounce; a source latches on the edge its count reaches DEBOUNCE_CYCLES
  always_comb begin
    latch_now = '0;
    db_cnt_d  = db_cnt_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (!sos_button[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] != DB_W'(DEBOUNCE_CYCLES)) begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
      latch_now[i] = sos_button[i] && (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1));
      if (clear_done) begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Lowest set index of the latched sources
  always_comb begin
    lowest_src = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active_src_q[i]) begin
        lowest_src = SRC_W'(i);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    first_src_d = first_src_q;
    clear_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (|active_src_q) begin
          state_d     = ST_ALARM;
          first_src_d = lowest_src;
        end
      end
      ST_ALARM: begin
        hold_d = '0;
        // The entering edge already counts as the first held edge of the key
        if (clear_request && (sos_button == '0)) begin
          if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            clear_done = 1'b1;
          end else begin
            state_d = ST_CLEARING;
            hold_d  = HOLD_W'(1);
          end
        end
      end
      ST_CLEARING: begin
        if (!clear_request) begin
          state_d = ST_ALARM;
          hold_d  = '0;
        end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          clear_done = 1'b1;
        end else if (|sos_button) begin
          state_d = ST_ALARM;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end
    endcase

    if (clear_done) begin
      state_d     = ST_IDLE;
      hold_d      = '0;
      first_src_d = '0;
    end

    // A source latching on the clear-completion edge survives the clear
    active_src_d = clear_done ? latch_now : (active_src_q | latch_now);
    sos_mode_d   = (state_d != ST_IDLE);

`ifdef SOS_ALARM_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    alarm_led_d = alarm_led_q;
    if (state_d == ST_IDLE) begin
      blink_cnt_d = '0;
      alarm_led_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      blink_cnt_d = BLINK_W'(1);
      alarm_led_d = 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_HALF)) begin
      blink_cnt_d = BLINK_W'(1);
      alarm_led_d = ~alarm_led_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
`else
    alarm_led_d = (state_d != ST_IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      db_cnt_q     <= '0;
      active_src_q <= '0;
      first_src_q  <= '0;
      sos_mode_q   <= 1'b0;
      alarm_led_q  <= 1'b0;
`ifdef SOS_ALARM_BLINK_EN
      blink_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      db_cnt_q     <= db_cnt_d;
      active_src_q <= active_src_d;
      first_src_q  <= first_src_d;
      sos_mode_q   <= sos_mode_d;
      alarm_led_q  <= alarm_led_d;
`ifdef SOS_ALARM_BLINK_EN
      blink_cnt_q  <= blink_cnt_d;
`endif
    end
  end

  assign sos_mode   = sos_mode_q;
  assign active_src = active_src_q;
  assign first_src  = first_src_q;
  assign alarm_led  = alarm_led_q;

endmodule

// File: tb/tb_emergency_arbiter.sv
// Self-checking bench for emergency_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the emergency/clear rules.
module tb_emergency_arbiter;

  localparam int NS   = 4;
  localparam int DB   = 8;
  localparam int HOLD = 16;
  localparam int BH   = 4;

  logic          clk;
  logic          reset;
  logic [NS-1:0] sos_button;
  logic          clear_request;
  logic          sos_mode;
  logic [NS-1:0] active_src;
  logic [1:0]    first_src;
  logic          alarm_led;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_run [NS];
  logic [NS-1:0] m_lat;
  bit          m_emerg;
  bit          m_clr;
  int          m_hold;
  int          m_first;
  int          m_t;

  emergency_arbiter #(
    .N_SRC(NS), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .reset(reset), .sos_button(sos_button), .clear_request(clear_request),
    .sos_mode(sos_mode), .active_src(active_src), .first_src(first_src), .alarm_led(alarm_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lowest_of(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic exp_led();
    if (!m_emerg) return 1'b0;
`ifdef SOS_ALARM_BLINK_EN
    return ((m_t / BH) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  // One clock edge of the specification's rules, using the inputs seen at that edge
  task automatic model_step(input logic r, input logic [NS-1:0] b, input logic c);
    logic [NS-1:0] newl;
    bit done;
    newl = '0;
    done = 0;
    if (r) begin
      for (int i = 0; i < NS; i++) m_run[i] = 0;
      m_lat = '0; m_emerg = 0; m_clr = 0; m_hold = 0; m_first = 0; m_t = 0;
      return;
    end
    for (int i = 0; i < NS; i++) begin
      if (b[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) newl[i] = 1'b1;
      end else begin
        m_run[i] = 0;
      end
    end
    if (!m_emerg) begin
      if (m_lat != 0) begin
        m_emerg = 1; m_first = lowest_of(m_lat); m_t = 0;
      end
    end else if (!m_clr) begin
      m_t++;
      if (c && b == 0) begin
        if (HOLD <= 1) done = 1;
        else begin m_clr = 1; m_hold = 1; end
      end
    end else begin
      m_t++;
      if (!c) begin m_clr = 0; m_hold = 0; end
      else if (m_hold + 1 >= HOLD) done = 1;
      else if (b != 0) begin m_clr = 0; m_hold = 0; end
      else m_hold++;
    end
    if (done) begin
      m_emerg = 0; m_clr = 0; m_hold = 0; m_first = 0; m_t = 0;
      m_lat = newl;
      for (int i = 0; i < NS; i++) m_run[i] = 0;
    end else begin
      m_lat = m_lat | newl;
    end
  endtask

  task automatic tick(input logic r, input logic [NS-1:0] b, input logic c);
    reset = r; sos_button = b; clear_request = c;
    @(posedge clk);
    model_step(r, b, c);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 4'b1111, 1'b1);
    tick(1'b1, 4'b1111, 1'b1);
    checks++; if (sos_mode !== 1'b0) begin errors++; $display("FAIL reset_sos got %0b exp 0", sos_mode); end
    checks++; if (active_src !== 4'b0000) begin errors++; $display("FAIL reset_active got %b exp 0000", active_src); end
    checks++; if (first_src !== 2'd0) begin errors++; $display("FAIL reset_first got %0d exp 0", first_src); end
    checks++; if (alarm_led !== 1'b0) begin errors++; $display("FAIL reset_led got %0b exp 0", alarm_led); end
    tick(1'b0, 4'b0000, 1'b0);
  endtask

  task automatic test_short_press();
    for (int k = 0; k < 7; k++) tick(1'b0, 4'b0100, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 4'b0000, 1'b0);
      checks++; if (active_src !== 4'b0000 || sos_mode !== 1'b0) begin
        errors++; $display("FAIL short_press active %b sos %0b exp 0000 0", active_src, sos_mode);
      end
    end
  endtask

  task automatic test_latch_blink();
    logic led_seq [9];
`ifdef SOS_ALARM_BLINK_EN
    led_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    led_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int k = 0; k < 8; k++) tick(1'b0, 4'b0100, 1'b0);
    checks++; if (active_src !== 4'b0100 || sos_mode !== 1'b0) begin
      errors++; $display("FAIL latch_edge8 active %b sos %0b exp 0100 0", active_src, sos_mode);
    end
    for (int k = 0; k < 9; k++) begin
      tick(1'b0, 4'b0000, 1'b0);
      if (k == 0) begin
        checks++; if (sos_mode !== 1'b1 || first_src !== 2'd2) begin
          errors++; $display("FAIL latch_edge9 sos %0b first %0d exp 1 2", sos_mode, first_src);
        end
      end
      checks++; if (alarm_led !== led_seq[k]) begin
        errors++; $display("FAIL blink_seq step %0d got %0b exp %0b", k, alarm_led, led_seq[k]);
      end
    end
  endtask

  task automatic test_multi_src();
    tick(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 9; k++) tick(1'b0, 4'b1010, 1'b0);
    checks++; if (first_src !== 2'd1 || active_src !== 4'b1010 || sos_mode !== 1'b1) begin
      errors++; $display("FAIL multi_first first %0d active %b sos %0b exp 1 1010 1", first_src, active_src, sos_mode);
    end
    for (int k = 0; k < 8; k++) tick(1'b0, 4'b0001, 1'b0);
    checks++; if (active_src !== 4'b1011 || first_src !== 2'd1) begin
      errors++; $display("FAIL multi_late active %b first %0d exp 1011 1", active_src, first_src);
    end
  endtask

  task automatic test_clear();
    tick(1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 10; k++) tick(1'b0, 4'b0000, 1'b1);
    tick(1'b0, 4'b0000, 1'b0);
    checks++; if (sos_mode !== 1'b1 || active_src !== 4'b1011) begin
      errors++; $display("FAIL clear_abort sos %0b active %b exp 1 1011", sos_mode, active_src);
    end
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, 4'b0000, 1'b1);
      if (k == 15) begin
        checks++; if (sos_mode !== 1'b1) begin errors++; $display("FAIL clear_early sos %0b exp 1", sos_mode); end
      end
    end
    checks++; if (sos_mode !== 1'b0 || active_src !== 4'b0000 || first_src !== 2'd0 || alarm_led !== 1'b0) begin
      errors++; $display("FAIL clear_done sos %0b active %b first %0d led %0b exp all 0", sos_mode, active_src, first_src, alarm_led);
    end
    for (int k = 0; k < 20; k++) tick(1'b0, 4'b0000, 1'b1);
    checks++; if (sos_mode !== 1'b0 || active_src !== 4'b0000) begin
      errors++; $display("FAIL clear_in_idle sos %0b active %b exp 0 0000", sos_mode, active_src);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 8; k++) tick(1'b0, 4'b0001, 1'b0);
    tick(1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b0, 4'b0000, 1'b1);
    tick(1'b1, 4'b0001, 1'b1);
    checks++; if (sos_mode !== 1'b0 || active_src !== 4'b0000 || first_src !== 2'd0 || alarm_led !== 1'b0) begin
      errors++; $display("FAIL reset_mid sos %0b active %b first %0d led %0b exp all 0", sos_mode, active_src, first_src, alarm_led);
    end
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 4'b0001, 1'b0);
      if (k == 7) begin
        checks++; if (active_src !== 4'b0000) begin errors++; $display("FAIL reset_hold_early active %b exp 0000", active_src); end
      end
    end
    checks++; if (active_src !== 4'b0001 || sos_mode !== 1'b0) begin
      errors++; $display("FAIL reset_hold_latch active %b sos %0b exp 0001 0", active_src, sos_mode);
    end
  endtask

  task automatic test_random();
    int cyc = 0;
    logic r;
    logic [NS-1:0] b;
    logic c;
    int len;
    tick(1'b1, 4'b0000, 1'b0);
    for (int seg = 0; seg < 220; seg++) begin
      len = int'($urandom_range(1, 24));
      r = ($urandom_range(0, 49) == 0);
      b = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      c = ($urandom_range(0, 9) < 6);
      for (int k = 0; k < len; k++) begin
        tick(r && (k == 0), b, c);
        cyc++;
        checks++; if (sos_mode !== m_emerg) begin
          errors++; $display("FAIL rand_sos cyc %0d got %0b exp %0b", cyc, sos_mode, m_emerg);
        end
        checks++; if (active_src !== m_lat) begin
          errors++; $display("FAIL rand_active cyc %0d got %b exp %b", cyc, active_src, m_lat);
        end
        checks++; if (first_src !== 2'(m_first)) begin
          errors++; $display("FAIL rand_first cyc %0d got %0d exp %0d", cyc, first_src, m_first);
        end
        checks++; if (alarm_led !== exp_led()) begin
          errors++; $display("FAIL rand_led cyc %0d got %0b exp %0b", cyc, alarm_led, exp_led());
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    sos_button = '0;
    clear_request = 1'b0;
    for (int i = 0; i < NS; i++) m_run[i] = 0;
    m_lat = '0; m_emerg = 0; m_clr = 0; m_hold = 0; m_first = 0; m_t = 0;
    test_reset();
    test_short_press();
    test_latch_blink();
    test_multi_src();
    test_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
